fft_sample_server: RTL and testbench



---
 rtl/fft_sample_server_if.sv | 29 ++
 rtl/fft_sample_server.sv | 148 ++++++++++++++
 tb/tb_fft_sample_server.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fft_sample_server_if.sv
// fft_sample_server_if: request/response link between the sample source,
// the first FFT stage and the sample server.
//   master: sample source / FFT consumer side
//   slave : fft_sample_server side
interface fft_sample_server_if #(
  parameter int Q     = 15,
  parameter int LOG2N = 3
);
  logic             sample_valid;
  logic [Q:0]       sample_real;
  logic [Q:0]       sample_imag;
  logic             sample_ready;
  logic             valid_packet;
  logic             valid_request;
  logic             data_valid;
  logic [Q:0]       data_real;
  logic [Q:0]       data_imag;
  logic [LOG2N-1:0] data_index;

  modport master (
    output sample_valid, sample_real, sample_imag, valid_request,
    input  sample_ready, valid_packet, data_valid, data_real, data_imag, data_index
  );

  modport slave (
    input  sample_valid, sample_real, sample_imag, valid_request,
    output sample_ready, valid_packet, data_valid, data_real, data_imag, data_index
  );
endinterface

// File: rtl/fft_sample_server.sv
// fft_sample_server: ping-pong buffer of N complex samples. One bank fills
// while the other is served one sample per accepted request, in bit-reversed
// address order. Optional build macro FFT_SAMPLE_SERVER_OVERRUN_CNT_EN adds an
// 8-bit saturating count of dropped writes and ignored requests.
module fft_sample_server #(
  parameter int Q     = 15,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic               clk,
  input  logic               reset,
  fft_sample_server_if.slave bus
`ifdef FFT_SAMPLE_SERVER_OVERRUN_CNT_EN
  ,
  output logic [7:0]         overrun_count
`endif
);
  localparam int W = 2 * (Q + 1);

  // Both banks live in one array, addressed {bank, offset}; real part in the upper half.
  logic [W-1:0]     mem_q [2*N];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             gap_q, gap_d;
  logic             valid_packet_q, valid_packet_d;
  logic             data_valid_q;
  logic [Q:0]       data_real_q, data_imag_q;
  logic [LOG2N-1:0] data_index_q;

  logic [LOG2N-1:0] rd_addr;
  logic             wr_fire, rd_fire, wr_last, rd_last;

  // Read address is the read count with its bits mirrored.
  generate
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign rd_addr[gi] = rd_cnt_q[LOG2N-1-gi];
    end
  endgenerate

  // A write and a read never target the same bank: writes need an empty
  // write bank, reads need a full read bank.
  assign wr_fire = bus.sample_valid && !full_q[wr_bank_q];
  assign rd_fire = bus.valid_request && valid_packet_q;
  assign wr_last = wr_fire && (wr_ptr_q == LOG2N'(N - 1));
  assign rd_last = rd_fire && (rd_cnt_q == LOG2N'(N - 1));

  assign bus.sample_ready = !full_q[wr_bank_q];
  assign bus.valid_packet = valid_packet_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.data_real    = data_real_q;
  assign bus.data_imag    = data_imag_q;
  assign bus.data_index   = data_index_q;

  // Next-state of the bank pointers and full flags; fill and release may coincide.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_cnt_d  = rd_cnt_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
    // One-cycle gap after each release keeps frames visibly separated.
    gap_d          = rd_last;
    valid_packet_d = full_d[rd_bank_d] && !gap_d;
  end

  // Control state register; valid_packet is registered from next-state so it
  // rises the cycle after the frame's last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q         <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_cnt_q       <= '0;
      gap_q          <= 1'b0;
      valid_packet_q <= 1'b0;
      data_valid_q   <= 1'b0;
    end else begin
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_cnt_q       <= rd_cnt_d;
      gap_q          <= gap_d;
      valid_packet_q <= valid_packet_d;
      data_valid_q   <= rd_fire;
    end
  end

  // Sample memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[{wr_bank_q, wr_ptr_q}] <= {bus.sample_real, bus.sample_imag};
    end
  end

  // Registered read port; output holds between accepted requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_real_q  <= '0;
      data_imag_q  <= '0;
      data_index_q <= '0;
    end else if (rd_fire) begin
      {data_real_q, data_imag_q} <= mem_q[{rd_bank_q, rd_addr}];
      data_index_q               <= rd_addr;
    end
  end

`ifdef FFT_SAMPLE_SERVER_OVERRUN_CNT_EN
  logic [7:0] overrun_q, overrun_d;
  logic [8:0] overrun_sum;
  logic       wr_drop, rq_drop;

  assign wr_drop     = bus.sample_valid && full_q[wr_bank_q];
  assign rq_drop     = bus.valid_request && !valid_packet_q;
  assign overrun_sum = {1'b0, overrun_q} + {8'd0, wr_drop} + {8'd0, rq_drop};
  assign overrun_d   = overrun_sum[8] ? 8'hFF : overrun_sum[7:0];
  assign overrun_count = overrun_q;

  // Saturating overrun counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end
`endif

endmodule

// File: tb/tb_fft_sample_server.sv
// tb_fft_sample_server: directed scenarios plus random traffic, checked every
// cycle against a frame-queue reference model.
module tb_fft_sample_server;
  localparam int Q     = 15;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int SW    = Q + 1;

  logic clk;
  logic reset;

  fft_sample_server_if #(.Q(Q), .LOG2N(LOG2N)) bus ();

`ifdef FFT_SAMPLE_SERVER_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
`endif

  fft_sample_server #(.Q(Q), .N(N), .LOG2N(LOG2N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FFT_SAMPLE_SERVER_OVERRUN_CNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: completed frames queued back to back, plus a partial frame.
  logic [2*SW-1:0]  fq[$];
  logic [2*SW-1:0]  pq[$];
  int               served;
  bit               gap;
  bit               vp;
  bit               edv;
  logic [Q:0]       er, ei;
  logic [LOG2N-1:0] eidx;
  int               eovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // One clock cycle: drive inputs, advance the model at the edge, check all outputs.
  task automatic cyc(input bit sv, input logic [Q:0] sr, input logic [Q:0] si,
                     input bit rq, input bit rst);
    bit rdy, acc_w, acc_r;
    bus.sample_valid  = sv;
    bus.sample_real   = sr;
    bus.sample_imag   = si;
    bus.valid_request = rq;
    reset             = rst;
    @(posedge clk);
    if (rst) begin
      fq.delete();
      pq.delete();
      served = 0;
      gap    = 0;
      vp     = 0;
      edv    = 0;
      er     = '0;
      ei     = '0;
      eidx   = '0;
      eovr   = 0;
    end else begin
      rdy   = (fq.size() < 2 * N);
      acc_w = sv && rdy;
      acc_r = rq && vp;
      eovr  = eovr + int'(sv && !rdy) + int'(rq && !vp);
      if (eovr > 255) eovr = 255;
      edv = acc_r;
      gap = 0;
      if (acc_r) begin
        eidx      = LOG2N'(bitrev(served));
        {er, ei}  = fq[eidx];
        served++;
        if (served == N) begin
          repeat (N) void'(fq.pop_front());
          served = 0;
          gap    = 1;
        end
        $display("rsp idx=%0d re=%0d im=%0d", eidx, $signed(er), $signed(ei));
      end
      if (acc_w) begin
        pq.push_back({sr, si});
        if (pq.size() == N) begin
          for (int k = 0; k < N; k++) fq.push_back(pq[k]);
          pq.delete();
        end
      end
      vp = (fq.size() > 0) && !gap;
    end
    #1;
    check_eq("sample_ready", 32'(bus.sample_ready), 32'(fq.size() < 2 * N));
    check_eq("valid_packet", 32'(bus.valid_packet), 32'(vp));
    check_eq("data_valid",   32'(bus.data_valid),   32'(edv));
    check_eq("data_real",    32'(bus.data_real),    32'(er));
    check_eq("data_imag",    32'(bus.data_imag),    32'(ei));
    check_eq("data_index",   32'(bus.data_index),   32'(eidx));
`ifdef FFT_SAMPLE_SERVER_OVERRUN_CNT_EN
    check_eq("overrun_count", 32'(overrun_count), 32'(eovr));
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic write_run(input int base, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, SW'(base + k), SW'(-(base + k)), 1'b0, 1'b0);
  endtask

  task automatic serve(input int n, input int spacing);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
      idle(spacing - 1);
    end
  endtask

  initial begin
    bus.sample_valid  = 1'b0;
    bus.sample_real   = '0;
    bus.sample_imag   = '0;
    bus.valid_request = 1'b0;
    reset             = 1'b1;

    // Frame order with spaced requests
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    write_run(0, 8);
    serve(8, 3);
    idle(2);

    // Ping-pong: two frames back to back, continuous requests across the gap
    write_run(0, 16);
    cyc(1'b1, SW'(77), SW'(77), 1'b0, 1'b0);
    serve(18, 1);
    idle(2);

    // Overrun write while both banks are full
    write_run(50, 16);
    cyc(1'b1, SW'(99), SW'(99), 1'b0, 1'b0);
    serve(17, 1);
    idle(2);

    // Early request with nothing to serve
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Reset mid-serve, then refill
    write_run(100, 8);
    serve(3, 1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    write_run(20, 8);
    serve(8, 1);
    idle(2);

    // Last request of one bank coincides with the final write of the other
    write_run(30, 8);
    for (int k = 0; k < 8; k++) cyc(1'b1, SW'(40 + k), SW'(-(40 + k)), 1'b1, 1'b0);
    idle(1);
    serve(9, 1);
    idle(2);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom % 4) != 0, SW'($urandom), SW'($urandom),
          ($urandom % 3) == 0, ($urandom % 250) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
